// File: rtl/keypad_entry_sequencer.sv
// Keypad operand entry: debounces decoded keys, builds signed decimal values and
// commits them one by one to the regression core over a valid/ready handshake.
module keypad_entry_sequencer #(
    parameter int ELEM_WIDTH      = 12,
    parameter int NUM_ELEMS       = 9,
    parameter int MAX_DIGITS      = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int IDX_W          = $clog2(NUM_ELEMS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  core_ready,
    output logic [ELEM_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  input_done,
    output logic [IDX_W-1:0]      elem_index,
    output logic [9:0]            entry_value,
    output logic                  negative,
    output logic [1:0]            digit_count,
    output logic                  busy,
    output logic                  err
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int WW = ELEM_WIDTH + 10;
    localparam logic [WW-1:0] SAT_MAX = (WW'(1) << (ELEM_WIDTH - 1)) - WW'(1);

    typedef enum logic [1:0] {
        ST_ENTRY     = 2'd0,
        ST_WAIT_CORE = 2'd1,
        ST_DONE      = 2'd2,
        ST_ERROR     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic                  ev_q, ev_d;
    logic [3:0]            code_q, code_d;
    logic [9:0]            entry_q, entry_d;
    logic                  neg_q, neg_d;
    logic [1:0]            dcnt_q, dcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ELEM_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  fire_s;
    logic                  handshake_s;
    logic [13:0]           acc_s;
    logic [WW-1:0]         wide_s;
    logic [WW-1:0]         mag_s;
    logic [ELEM_WIDTH-1:0] mag_e_s;
    logic [ELEM_WIDTH-1:0] commit_s;

    assign handshake_s = (state_q == ST_WAIT_CORE) && core_ready;

    // Debounce: count stable cycles of the level that would flip the detector
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        fire_s  = 1'b0;
        if (key_valid == armed_q) begin
            if (cnt_q == DEB_LAST) begin
                cnt_d   = '0;
                armed_d = ~armed_q;
                fire_s  = armed_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        ev_d   = fire_s && !handshake_s;
        code_d = fire_s ? key_code : code_q;
    end

    // Operand arithmetic: digit accumulation and saturated signed commit value
    always_comb begin
        acc_s    = 14'(entry_q) * 14'd10 + 14'(code_q);
        wide_s   = WW'(entry_q);
        mag_s    = (wide_s > SAT_MAX) ? SAT_MAX : wide_s;
        mag_e_s  = mag_s[ELEM_WIDTH-1:0];
        commit_s = neg_q ? (~mag_e_s + ELEM_WIDTH'(1)) : mag_e_s;
    end

    // Entry/commit state machine
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        neg_d   = neg_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_ENTRY: begin
                if (ev_q) begin
                    case (code_q)
                        4'hA: neg_d = ~neg_q;
                        4'hB: begin
                            entry_d = 10'd0;
                            neg_d   = 1'b0;
                            dcnt_d  = 2'd0;
                        end
                        4'hC: begin
                            entry_d = 10'd0;
                            neg_d   = 1'b0;
                            dcnt_d  = 2'd0;
                            idx_d   = '0;
                        end
                        4'hD: begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end
                        4'hE: begin
                            if (dcnt_q != 2'd0) begin
                                data_d  = commit_s;
                                state_d = ST_WAIT_CORE;
                            end else begin
                                state_d = ST_ENTRY;
                            end
                        end
                        4'hF: state_d = ST_ENTRY;
                        default: begin
                            if (dcnt_q < 2'(MAX_DIGITS)) begin
                                entry_d = acc_s[9:0];
                                dcnt_d  = dcnt_q + 2'd1;
                            end else begin
                                dcnt_d = dcnt_q;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_WAIT_CORE: begin
                if (core_ready) begin
                    idx_d   = idx_q + IDX_W'(1);
                    entry_d = 10'd0;
                    neg_d   = 1'b0;
                    dcnt_d  = 2'd0;
                    if (idx_q + IDX_W'(1) == IDX_W'(NUM_ELEMS)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else begin
                    state_d = ST_WAIT_CORE;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (ev_q && code_q == 4'hC) begin
                    entry_d = 10'd0;
                    neg_d   = 1'b0;
                    dcnt_d  = 2'd0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ENTRY;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            ev_q    <= 1'b0;
            code_q  <= 4'hF;
            entry_q <= 10'd0;
            neg_q   <= 1'b0;
            dcnt_q  <= 2'd0;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            ev_q    <= ev_d;
            code_q  <= code_d;
            entry_q <= entry_d;
            neg_q   <= neg_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = handshake_s;
    assign input_done  = done_q;
    assign elem_index  = idx_q;
    assign entry_value = entry_q;
    assign negative    = neg_q;
    assign digit_count = dcnt_q;
    assign busy        = (state_q == ST_WAIT_CORE);
    assign err         = err_q;
endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Directed bench for keypad_entry_sequencer: key presses via a debounce-aware task,
// commit/done strobes tracked by a posedge monitor, checks at negedges.
module tb_keypad_entry_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        core_ready;
    logic [11:0] data_out;
    logic        data_valid;
    logic        input_done;
    logic [3:0]  elem_index;
    logic [9:0]  entry_value;
    logic        negative;
    logic [1:0]  digit_count;
    logic        busy;
    logic        err;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int dv_cnt   = 0;
    int dv_cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int dv_base;
    int done_base;

    keypad_entry_sequencer dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .core_ready(core_ready), .data_out(data_out), .data_valid(data_valid),
        .input_done(input_done), .elem_index(elem_index), .entry_value(entry_value),
        .negative(negative), .digit_count(digit_count), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    // Strobe monitor
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
        end
        if (input_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        key_code  = code;
        key_valid = 1'b1;
        repeat (hold) @(negedge clock);
        key_valid = 1'b0;
        key_code  = 4'hF;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'hF; core_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_elem_index", 32'(elem_index), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_entry", 32'(entry_value), 32'h0);

        // 1: 1,2,3,E commits 123
        dv_base = dv_cnt;
        press(4'h1, 20); press(4'h2, 20); press(4'h3, 20);
        chk("t1_entry", 32'(entry_value), 32'd123);
        chk("t1_digits", 32'(digit_count), 32'd3);
        press(4'hE, 20);
        chk("t1_dv_count", 32'(dv_cnt - dv_base), 32'd1);
        chk("t1_data_out", 32'(data_out), 32'h07B);
        chk("t1_elem_index", 32'(elem_index), 32'd1);
        chk("t1_entry_clr", 32'(entry_value), 32'd0);

        // 2: A,4,5,E commits -45; four 9s cap at three digits
        press(4'hA, 20);
        chk("t2_negative", 32'(negative), 32'd1);
        press(4'h4, 20); press(4'h5, 20); press(4'hE, 20);
        chk("t2_data_out", 32'(data_out), 32'hFD3);
        chk("t2_elem_index", 32'(elem_index), 32'd2);
        chk("t2_neg_clr", 32'(negative), 32'd0);
        press(4'h9, 20); press(4'h9, 20); press(4'h9, 20); press(4'h9, 20);
        chk("t2_entry999", 32'(entry_value), 32'd999);
        chk("t2_digits3", 32'(digit_count), 32'd3);
        press(4'hB, 20);
        chk("t2_clear_entry", 32'(entry_value), 32'd0);
        chk("t2_clear_digits", 32'(digit_count), 32'd0);

        // 3: 15-cycle glitch is ignored; a 200-cycle hold gives one event
        key_code = 4'h1; key_valid = 1'b1;
        repeat (15) @(negedge clock);
        key_valid = 1'b0; key_code = 4'hF;
        repeat (20) @(negedge clock);
        chk("t3_glitch_entry", 32'(entry_value), 32'd0);
        chk("t3_glitch_digits", 32'(digit_count), 32'd0);
        press(4'h7, 200);
        chk("t3_hold_entry", 32'(entry_value), 32'd7);
        chk("t3_hold_digits", 32'(digit_count), 32'd1);

        // 4: core stalls; keys during WAIT_CORE are dropped
        press(4'hB, 20);
        core_ready = 1'b0;
        dv_base = dv_cnt;
        press(4'h8, 20); press(4'hE, 20);
        press(4'h5, 20);
        repeat (10) @(negedge clock);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_no_dv", 32'(dv_cnt - dv_base), 32'd0);
        chk("t4_entry_held", 32'(entry_value), 32'd8);
        chk("t4_digits_held", 32'(digit_count), 32'd1);
        core_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("t4_dv_once", 32'(dv_cnt - dv_base), 32'd1);
        chk("t4_data_out", 32'(data_out), 32'h008);
        chk("t4_elem_index", 32'(elem_index), 32'd3);
        chk("t4_busy_clr", 32'(busy), 32'd0);
        repeat (10) @(negedge clock);
        chk("t4_no_extra_dv", 32'(dv_cnt - dv_base), 32'd1);

        // 5: complete all nine elements
        done_base = done_cnt;
        for (int i = 1; i <= 5; i++) begin
            press(4'(i), 20); press(4'hE, 20);
        end
        chk("t5_no_early_done", 32'(done_cnt - done_base), 32'd0);
        chk("t5_idx8", 32'(elem_index), 32'd8);
        press(4'h6, 20); press(4'hE, 20);
        chk("t5_done_once", 32'(done_cnt - done_base), 32'd1);
        chk("t5_done_latency", 32'(done_cyc - dv_cyc), 32'd1);
        chk("t5_idx9", 32'(elem_index), 32'd9);
        chk("t5_last_data", 32'(data_out), 32'h006);
        press(4'h3, 20);
        chk("t5_digit_ignored", 32'(entry_value), 32'd0);
        chk("t5_digits_ignored", 32'(digit_count), 32'd0);
        press(4'hC, 20);
        chk("t5_restart_idx", 32'(elem_index), 32'd0);

        // 6: premature done, restart, then reset mid-handshake
        press(4'h4, 20); press(4'hE, 20);
        press(4'h5, 20); press(4'hE, 20);
        chk("t6_idx2", 32'(elem_index), 32'd2);
        press(4'hD, 20);
        chk("t6_err_set", 32'(err), 32'd1);
        press(4'h5, 20);
        chk("t6_entry_blocked", 32'(entry_value), 32'd0);
        chk("t6_err_held", 32'(err), 32'd1);
        press(4'hC, 20);
        chk("t6_err_clr", 32'(err), 32'd0);
        chk("t6_idx_clr", 32'(elem_index), 32'd0);
        core_ready = 1'b0;
        press(4'h2, 20); press(4'hE, 20);
        chk("t6_busy_wait", 32'(busy), 32'd1);
        chk("t6_data_latched", 32'(data_out), 32'h002);
        dv_base = dv_cnt; done_base = done_cnt;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_data", 32'(data_out), 32'd0);
        chk("t6_rst_dv", 32'(data_valid), 32'd0);
        chk("t6_rst_entry", 32'(entry_value), 32'd0);
        chk("t6_rst_digits", 32'(digit_count), 32'd0);
        core_ready = 1'b1;
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("t6_abort_dv", 32'(dv_cnt - dv_base), 32'd0);
        chk("t6_abort_done", 32'(done_cnt - done_base), 32'd0);
        chk("t6_abort_idx", 32'(elem_index), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
